// File: rtl/ps2kb_pkg.sv
// Shared definitions for the PS/2 keyboard path: handshake FSM states and fixed byte codes.
package ps2kb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ASSERT = 2'd1,
      GAP    = 2'd2
   } kb_state_t;

   localparam logic [7:0] OVERRUN_CODE     = 8'hFF;
   localparam logic [7:0] SCANCODE_CLEARED = 8'h00;

endpackage

// File: rtl/ps2_scancode_fifo.sv
// Synchronous byte FIFO, 2^DEPTH_LOG2 entries, head visible combinationally on dout.
// A push while full is taken only when a pop happens in the same cycle.
module ps2_scancode_fifo
   import ps2kb_pkg::*;
#(
   parameter int DEPTH_LOG2 = 3
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  push,
   input  logic                  pop,
   input  logic [7:0]            din,
   output logic [7:0]            dout,
   output logic [DEPTH_LOG2:0]   count,
   output logic                  full,
   output logic                  empty
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] CNT_FULL = (DEPTH_LOG2 + 1)'(DEPTH);

   logic [7:0]            mem [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr;
   logic [DEPTH_LOG2-1:0] rd_ptr;
   logic                  wr_en;
   logic                  rd_en;

   assign full  = (count == CNT_FULL);
   assign empty = (count == '0);
   assign rd_en = pop && !empty;
   assign wr_en = push && (!full || rd_en);
   assign dout  = mem[rd_ptr];

   always_ff @(posedge clock) begin
      if (wr_en)
         mem[wr_ptr] <= din;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en)
            wr_ptr <= wr_ptr + 1'b1;
         if (rd_en)
            rd_ptr <= rd_ptr + 1'b1;
         case ({wr_en, rd_en})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/ps2_scancode_buffer.sv
// Queues set-1 bytes and presents them with XT IRQ/clear handshake and an enforced idle gap.
// Optional PS2_BUFFER_OVERRUN_CODE_EN: after a drop, queue 8'hFF once room frees up.
module ps2_scancode_buffer
   import ps2kb_pkg::*;
#(
   parameter int FIFO_DEPTH_LOG2 = 3,
   parameter int IRQ_GAP_CYCLES  = 16
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [7:0] ps2_data,
   input  logic       ps2_valid,
   input  logic       clear_keycode,
   output logic [7:0] scancode,
   output logic       keybord_irq,
   output logic       buffer_overflow
);

   localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
   localparam logic [FIFO_DEPTH_LOG2:0] CNT_FULL = (FIFO_DEPTH_LOG2 + 1)'(DEPTH);
   localparam int GAP_W = $clog2(IRQ_GAP_CYCLES + 1);
   localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(IRQ_GAP_CYCLES - 1);

   kb_state_t                state;
   logic [GAP_W-1:0]         gap_cnt;
   logic                     load;
   logic                     room;
   logic                     fifo_push;
   logic [7:0]               fifo_din;
   logic [7:0]               head;
   logic [FIFO_DEPTH_LOG2:0] fifo_count;
   logic                     fifo_full;
   logic                     fifo_empty;
   logic                     drop;

   assign load = (state == IDLE) && !fifo_empty && !clear_keycode;
   assign room = (fifo_count < CNT_FULL);

`ifdef PS2_BUFFER_OVERRUN_CODE_EN
   logic overrun_pending;
   logic insert_code;

   // While pending, the next free slot is reserved for the overrun marker.
   assign insert_code = overrun_pending && room;
   assign fifo_push   = overrun_pending ? insert_code : (ps2_valid && (room || load));
   assign fifo_din    = overrun_pending ? OVERRUN_CODE : ps2_data;
   assign drop        = ps2_valid && (overrun_pending || (!room && !load));

   always_ff @(posedge clock) begin
      if (reset)
         overrun_pending <= 1'b0;
      else if (insert_code)
         overrun_pending <= 1'b0;
      else if (drop)
         overrun_pending <= 1'b1;
   end
`else
   assign fifo_push = ps2_valid && (room || load);
   assign fifo_din  = ps2_data;
   assign drop      = ps2_valid && !room && !load;
`endif

   ps2_scancode_fifo #(
      .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
   ) u_fifo (
      .clock (clock),
      .reset (reset),
      .push  (fifo_push),
      .pop   (load),
      .din   (fifo_din),
      .dout  (head),
      .count (fifo_count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_ff @(posedge clock) begin
      if (!reset)
         assert (fifo_full == (fifo_count == CNT_FULL));
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state           <= IDLE;
         scancode        <= SCANCODE_CLEARED;
         keybord_irq     <= 1'b0;
         gap_cnt         <= '0;
         buffer_overflow <= 1'b0;
      end else begin
         buffer_overflow <= drop;
         case (state)
            IDLE: begin
               if (load) begin
                  scancode    <= head;
                  keybord_irq <= 1'b1;
                  state       <= ASSERT;
               end
            end
            ASSERT: begin
               if (clear_keycode) begin
                  scancode    <= SCANCODE_CLEARED;
                  keybord_irq <= 1'b0;
                  gap_cnt     <= GAP_LOAD;
                  state       <= GAP;
               end
            end
            GAP: begin
               // Counter parks at zero until the PPI releases its clear line.
               if (gap_cnt != '0)
                  gap_cnt <= gap_cnt - 1'b1;
               else if (!clear_keycode)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ps2_scancode_buffer.sv
// Directed bench for ps2_scancode_buffer: handshake timing, ordering, overflow, reset.
module tb_ps2_scancode_buffer;

   localparam int G     = 16;
   localparam int LIMIT = 60;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] ps2_data = 8'h00;
   logic       ps2_valid = 1'b0;
   logic       clear_keycode = 1'b0;
   logic [7:0] scancode;
   logic       keybord_irq;
   logic       buffer_overflow;

   int vectors = 0;
   int miscompares = 0;

   ps2_scancode_buffer #(
      .FIFO_DEPTH_LOG2 (3),
      .IRQ_GAP_CYCLES  (G)
   ) dut (
      .clock           (clock),
      .reset           (reset),
      .ps2_data        (ps2_data),
      .ps2_valid       (ps2_valid),
      .clear_keycode   (clear_keycode),
      .scancode        (scancode),
      .keybord_irq     (keybord_irq),
      .buffer_overflow (buffer_overflow)
   );

   always #5 clock = ~clock;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      assert (got === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic push_byte(input logic [7:0] d);
      ps2_data  = d;
      ps2_valid = 1'b1;
      tick();
      ps2_valid = 1'b0;
   endtask

   task automatic wait_irq(output int n);
      n = 0;
      while (keybord_irq !== 1'b1 && n < LIMIT) begin
         tick();
         n++;
      end
   endtask

   task automatic ack;
      clear_keycode = 1'b1;
      tick();
      clear_keycode = 1'b0;
   endtask

   task automatic ack_expect_next(input logic [7:0] exp, input string tag);
      int n;
      ack();
      wait_irq(n);
      chk({tag, " data"}, scancode, exp);
      chk({tag, " gap"}, n, G + 1);
   endtask

   task automatic ack_expect_none(input string tag);
      int n;
      ack();
      wait_irq(n);
      chk(tag, n, LIMIT);
   endtask

   initial begin
      int n;
      int ovf_cnt;
      logic irq_seen;

      // Reset state
      tick();
      tick();
      chk("reset scancode", scancode, 8'h00);
      chk("reset irq", keybord_irq, 1'b0);
      chk("reset overflow", buffer_overflow, 1'b0);
      reset = 1'b0;
      tick();

      // Single byte: visible two edges after the strobe edge
      push_byte(8'h1E);
      chk("t1 irq not yet", keybord_irq, 1'b0);
      tick();
      chk("t1 scancode", scancode, 8'h1E);
      chk("t1 irq", keybord_irq, 1'b1);
      repeat (3) tick();
      chk("t1 held", scancode, 8'h1E);
      ack();
      chk("t1 ack irq", keybord_irq, 1'b0);
      chk("t1 ack scancode", scancode, 8'h00);

      // Burst during the gap; first assertion exactly G+1 edges after ack
      push_byte(8'h2A);
      push_byte(8'h1E);
      push_byte(8'hAA);
      wait_irq(n);
      chk("t2 first gap", n + 3, G + 1);
      chk("t2 first data", scancode, 8'h2A);
      ack_expect_next(8'h1E, "t2 second");
      ack_expect_next(8'hAA, "t2 third");

      // Clear held high 40 cycles after the ack blocks the next byte
      push_byte(8'h3B);
      clear_keycode = 1'b1;
      irq_seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         tick();
         irq_seen = irq_seen | keybord_irq;
      end
      clear_keycode = 1'b0;
      chk("t3 irq during hold", irq_seen, 1'b0);
      tick();
      chk("t3 irq at release", keybord_irq, 1'b0);
      tick();
      chk("t3 irq after release", keybord_irq, 1'b1);
      chk("t3 data", scancode, 8'h3B);
      ack();
      repeat (G + 4) tick();

      // Ten bytes, no ack: one displayed, eight queued, the tenth dropped
      ovf_cnt = 0;
      for (int i = 1; i <= 10; i++) begin
         push_byte(8'(i));
         ovf_cnt += int'(buffer_overflow);
      end
      chk("t4 overflow pulse", buffer_overflow, 1'b1);
      tick();
      chk("t4 overflow clears", buffer_overflow, 1'b0);
      chk("t4 pulse count", ovf_cnt, 1);
      chk("t4 displayed", scancode, 8'h01);
      for (int i = 2; i <= 9; i++)
         ack_expect_next(8'(i), "t4 drain");
`ifdef PS2_BUFFER_OVERRUN_CODE_EN
      ack_expect_next(8'hFF, "t4 overrun code");
`endif
      ack_expect_none("t4 nothing further");

      // Full FIFO, push coincides with an IDLE load
      clear_keycode = 1'b1;
      for (int i = 0; i < 8; i++)
         push_byte(8'h11 + 8'(i));
      chk("t5 blocked by clear", keybord_irq, 1'b0);
      ps2_data      = 8'h19;
      ps2_valid     = 1'b1;
      clear_keycode = 1'b0;
      tick();
      ps2_valid = 1'b0;
      chk("t5 no overflow", buffer_overflow, 1'b0);
      chk("t5 irq", keybord_irq, 1'b1);
      chk("t5 head", scancode, 8'h11);
      push_byte(8'h1A);
      chk("t5 still full", buffer_overflow, 1'b1);
      for (int i = 2; i <= 9; i++)
         ack_expect_next(8'h10 + 8'(i), "t5 drain");
`ifdef PS2_BUFFER_OVERRUN_CODE_EN
      ack_expect_next(8'hFF, "t5 overrun code");
`endif
      ack_expect_none("t5 nothing further");

      // Reset mid-ASSERT with three bytes queued
      push_byte(8'h21);
      push_byte(8'h22);
      push_byte(8'h23);
      push_byte(8'h24);
      chk("t6 displayed", scancode, 8'h21);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("t6 reset irq", keybord_irq, 1'b0);
      chk("t6 reset scancode", scancode, 8'h00);
      chk("t6 reset overflow", buffer_overflow, 1'b0);
      wait_irq(n);
      chk("t6 no stale byte", n, LIMIT);
      push_byte(8'h55);
      tick();
      chk("t6 fresh byte", scancode, 8'h55);
      chk("t6 fresh irq", keybord_irq, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
